ex_mem_reg: RTL and testbench

EX/MEM pipeline register between the execute stage and the memory stage. It captures the execute-stage result, store data and control each cycle, and presents them to the memory stage as `ALURes`, `RdRqIn`, `Mem_Write`, `MemRead` and `flush`. It supports stall (hold), flush (bubble insertion) and optional store-data forwarding from writeback. It also keeps a running count of memory operations issued.

---
 rtl/ex_mem_if.sv | 42 ++++
 rtl/ex_mem_reg.sv | 115 +++++++++++
 tb/tb_ex_mem_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX/MEM bus: execute-stage and writeback inputs plus memory-stage outputs of the EX/MEM register.
interface ex_mem_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ex_valid;
    logic [31:0]      ex_alu_res;
    logic [31:0]      ex_store_data;
    logic [4:0]       ex_store_reg;
    logic             ex_mem_write;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_write_reg;
    logic             wb_reg_write;
    logic [4:0]       wb_write_reg;
    logic [31:0]      wb_write_data;

    logic             mem_valid;
    logic [31:0]      ALURes;
    logic [31:0]      RdRqIn;
    logic             Mem_Write;
    logic             MemRead;
    logic             mem_reg_write;
    logic [4:0]       mem_write_reg;
    logic             mem_flush;
    logic [CNT_W-1:0] mem_op_cnt;

    modport master (
        output ex_valid, ex_alu_res, ex_store_data, ex_store_reg, ex_mem_write,
               ex_mem_read, ex_reg_write, ex_write_reg,
               wb_reg_write, wb_write_reg, wb_write_data,
        input  mem_valid, ALURes, RdRqIn, Mem_Write, MemRead,
               mem_reg_write, mem_write_reg, mem_flush, mem_op_cnt
    );

    modport slave (
        input  ex_valid, ex_alu_res, ex_store_data, ex_store_reg, ex_mem_write,
               ex_mem_read, ex_reg_write, ex_write_reg,
               wb_reg_write, wb_write_reg, wb_write_data,
        output mem_valid, ALURes, RdRqIn, Mem_Write, MemRead,
               mem_reg_write, mem_write_reg, mem_flush, mem_op_cnt
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush, memory-op counter and optional
// writeback-to-store-data forwarding (enabled by defining EX_MEM_STORE_FWD_EN).
module ex_mem_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     stall,
    input  logic     flush,
    ex_mem_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic             valid_q, valid_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_read_q, mem_read_d;
    logic             reg_write_q, reg_write_d;
    logic             flush_q;
    logic [DW-1:0]    alu_q, alu_d;
    logic [DW-1:0]    store_q, store_d;
    logic [RW-1:0]    wreg_q, wreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap_fwd_c;
    logic             hold_fwd_c;

`ifdef EX_MEM_STORE_FWD_EN
    logic [RW-1:0]    st_reg_q, st_reg_d;

    // Writeback hit on the store source register; r0 never matches.
    assign cap_fwd_c  = bus.ex_mem_write & bus.wb_reg_write &
                        (bus.wb_write_reg == bus.ex_store_reg) & (bus.ex_store_reg != RW'(0));
    assign hold_fwd_c = mem_write_q & bus.wb_reg_write &
                        (bus.wb_write_reg == st_reg_q) & (st_reg_q != RW'(0));
`else
    assign cap_fwd_c  = 1'b0;
    assign hold_fwd_c = 1'b0;
`endif

    // Next-state: flush > stall > capture.
    always_comb begin
        valid_d     = valid_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        alu_d       = alu_q;
        store_d     = store_q;
        wreg_d      = wreg_q;
        cnt_d       = cnt_q;
`ifdef EX_MEM_STORE_FWD_EN
        st_reg_d    = st_reg_q;
`endif
        if (flush) begin
            valid_d     = 1'b0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
        end else if (stall) begin
            if (hold_fwd_c) store_d = bus.wb_write_data;
        end else begin
            valid_d     = bus.ex_valid;
            mem_write_d = bus.ex_mem_write & bus.ex_valid;
            mem_read_d  = bus.ex_mem_read  & bus.ex_valid;
            reg_write_d = bus.ex_reg_write & bus.ex_valid;
            alu_d       = bus.ex_alu_res;
            store_d     = cap_fwd_c ? bus.wb_write_data : bus.ex_store_data;
            wreg_d      = bus.ex_write_reg;
`ifdef EX_MEM_STORE_FWD_EN
            st_reg_d    = bus.ex_store_reg;
`endif
            if (bus.ex_valid & (bus.ex_mem_write | bus.ex_mem_read))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            flush_q     <= 1'b0;
            alu_q       <= '0;
            store_q     <= '0;
            wreg_q      <= '0;
            cnt_q       <= '0;
`ifdef EX_MEM_STORE_FWD_EN
            st_reg_q    <= '0;
`endif
        end else begin
            valid_q     <= valid_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            flush_q     <= flush;
            alu_q       <= alu_d;
            store_q     <= store_d;
            wreg_q      <= wreg_d;
            cnt_q       <= cnt_d;
`ifdef EX_MEM_STORE_FWD_EN
            st_reg_q    <= st_reg_d;
`endif
        end
    end

    assign bus.mem_valid     = valid_q;
    assign bus.ALURes        = alu_q;
    assign bus.RdRqIn        = store_q;
    assign bus.Mem_Write     = mem_write_q;
    assign bus.MemRead       = mem_read_q;
    assign bus.mem_reg_write = reg_write_q;
    assign bus.mem_write_reg = wreg_q;
    assign bus.mem_flush     = flush_q;
    assign bus.mem_op_cnt    = cnt_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg (counter narrowed to 4 bits to reach wrap).
module tb_ex_mem_reg;
    localparam int unsigned CNT_W = 4;
`ifdef EX_MEM_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [CNT_W-1:0] exp_cnt;

    ex_mem_if #(.CNT_W(CNT_W)) bus ();

    ex_mem_reg #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_res    = '0;
        bus.ex_store_data = '0;
        bus.ex_store_reg  = '0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_write_reg  = '0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_write_reg  = '0;
        bus.wb_write_data = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.mem_valid), 32'd0);
        chk({tag, ".alu"},   bus.ALURes, 32'd0);
        chk({tag, ".sdata"}, bus.RdRqIn, 32'd0);
        chk({tag, ".ctrl"},  32'({bus.Mem_Write, bus.MemRead, bus.mem_reg_write, bus.mem_flush}), 32'd0);
        chk({tag, ".wreg"},  32'(bus.mem_write_reg), 32'd0);
        chk({tag, ".cnt"},   32'(bus.mem_op_cnt), 32'd0);
    endtask

    initial begin
        clear_ex();
        #1;
        chk_all_zero("por");
        #2 rst = 1'b1;

        // Everything nonzero, then async reset mid-cycle
        bus.ex_valid = 1'b1; bus.ex_alu_res = 32'hA5A5_0001; bus.ex_store_data = 32'h0000_1234;
        bus.ex_store_reg = 5'd7; bus.ex_mem_write = 1'b1; bus.ex_mem_read = 1'b1;
        bus.ex_reg_write = 1'b1; bus.ex_write_reg = 5'd9; bus.wb_reg_write = 1'b1;
        bus.wb_write_reg = 5'd2; bus.wb_write_data = 32'h0000_DEAD;
        tick();
        chk("pre_rst.alu",   bus.ALURes, 32'hA5A5_0001);
        chk("pre_rst.sdata", bus.RdRqIn, 32'h0000_1234);
        chk("pre_rst.cnt",   32'(bus.mem_op_cnt), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        rst = 1'b1;
        exp_cnt = '0;

        // Load capture
        clear_ex();
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_alu_res = 32'h0000_0010;
        bus.ex_reg_write = 1'b1; bus.ex_write_reg = 5'd3;
        tick();
        exp_cnt = exp_cnt + CNT_W'(1);
        chk("cap.alu",   bus.ALURes, 32'h10);
        chk("cap.rd",    32'(bus.MemRead), 32'd1);
        chk("cap.wr",    32'(bus.Mem_Write), 32'd0);
        chk("cap.wreg",  32'(bus.mem_write_reg), 32'd3);
        chk("cap.valid", 32'(bus.mem_valid), 32'd1);
        chk("cap.cnt",   32'(bus.mem_op_cnt), 32'(exp_cnt));

        // Invalid slot never writes
        clear_ex();
        bus.ex_mem_write = 1'b1; bus.ex_reg_write = 1'b1;
        tick();
        chk("inv.wr",    32'(bus.Mem_Write), 32'd0);
        chk("inv.valid", 32'(bus.mem_valid), 32'd0);
        chk("inv.regwr", 32'(bus.mem_reg_write), 32'd0);
        chk("inv.cnt",   32'(bus.mem_op_cnt), 32'(exp_cnt));

        // Store, stall three cycles, then flush+stall
        clear_ex();
        bus.ex_valid = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_alu_res = 32'h20;
        bus.ex_store_data = 32'h55; bus.ex_store_reg = 5'd4;
        tick();
        exp_cnt = exp_cnt + CNT_W'(1);
        chk("st.wr",  32'(bus.Mem_Write), 32'd1);
        chk("st.cnt", 32'(bus.mem_op_cnt), 32'(exp_cnt));
        bus.ex_alu_res = 32'h99; bus.ex_mem_read = 1'b1; bus.ex_store_data = 32'h77;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.alu",   bus.ALURes, 32'h20);
            chk("stall.wr",    32'(bus.Mem_Write), 32'd1);
            chk("stall.sdata", bus.RdRqIn, 32'h55);
            chk("stall.cnt",   32'(bus.mem_op_cnt), 32'(exp_cnt));
            chk("stall.mflush", 32'(bus.mem_flush), 32'd0);
        end
        flush = 1'b1;
        tick();
        chk("flush.wr",     32'(bus.Mem_Write), 32'd0);
        chk("flush.valid",  32'(bus.mem_valid), 32'd0);
        chk("flush.alu",    bus.ALURes, 32'h20);
        chk("flush.mflush", 32'(bus.mem_flush), 32'd1);
        chk("flush.cnt",    32'(bus.mem_op_cnt), 32'(exp_cnt));
        flush = 1'b0;
        tick();
        chk("post_flush.mflush", 32'(bus.mem_flush), 32'd0);
        stall = 1'b0;

        // Stall-edge refresh of held store data
        clear_ex();
        bus.ex_valid = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_alu_res = 32'h40;
        bus.ex_store_data = 32'h1111; bus.ex_store_reg = 5'd6;
        tick();
        exp_cnt = exp_cnt + CNT_W'(1);
        chk("sfwd.cap", bus.RdRqIn, 32'h1111);
        stall = 1'b1;
        bus.wb_reg_write = 1'b1; bus.wb_write_reg = 5'd6; bus.wb_write_data = 32'hCAFE;
        tick();
        chk("sfwd.hold", bus.RdRqIn, FWD ? 32'hCAFE : 32'h1111);
        chk("sfwd.alu",  bus.ALURes, 32'h40);
        stall = 1'b0;

        // Capture-edge forwarding, then r0 exclusion
        clear_ex();
        bus.ex_valid = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_store_reg = 5'd5;
        bus.ex_store_data = 32'h1111; bus.wb_reg_write = 1'b1; bus.wb_write_reg = 5'd5;
        bus.wb_write_data = 32'hBEEF;
        tick();
        exp_cnt = exp_cnt + CNT_W'(1);
        chk("fwd.r5", bus.RdRqIn, FWD ? 32'hBEEF : 32'h1111);
        bus.ex_store_reg = 5'd0; bus.wb_write_reg = 5'd0;
        tick();
        exp_cnt = exp_cnt + CNT_W'(1);
        chk("fwd.r0", bus.RdRqIn, 32'h1111);
        chk("fwd.cnt", 32'(bus.mem_op_cnt), 32'(exp_cnt));

        // Sixteen loads walk the 4-bit counter through 15 -> 0
        clear_ex();
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_cnt = exp_cnt + CNT_W'(1);
            chk("wrap.cnt", 32'(bus.mem_op_cnt), 32'(exp_cnt));
        end
        chk("wrap.full_cycle", 32'(bus.mem_op_cnt), 32'd5);

        // Reset while stalled, then normal capture
        stall = 1'b1;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_stall.cnt",   32'(bus.mem_op_cnt), 32'd0);
        chk("rst_stall.valid", 32'(bus.mem_valid), 32'd0);
        rst = 1'b1;
        stall = 1'b0;
        bus.ex_alu_res = 32'h0000_0080;
        tick();
        chk("after_rst.cnt",   32'(bus.mem_op_cnt), 32'd1);
        chk("after_rst.valid", 32'(bus.mem_valid), 32'd1);
        chk("after_rst.rd",    32'(bus.MemRead), 32'd1);
        chk("after_rst.alu",   bus.ALURes, 32'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
